// File: rtl/johnson_decoder_pkg.sv
// Shared definitions for Johnson-code consumers: FSM state encodings and
// the index-width helper used to size decoded state indices.
package johnson_decoder_pkg;

   // Lock FSM encodings, kept as plain constants for legacy tool flows
   localparam logic [0:0] S_UNLOCKED = 1'b0;
   localparam logic [0:0] S_LOCKED   = 1'b1;

   // Width of a state index for an n-bit Johnson code (2n states)
   function automatic int johnson_idx_width(input int n);
      return $clog2(2 * n);
   endfunction

endpackage

// File: rtl/johnson_decoder_code_check.sv
// Combinational Johnson-code checker: flags whether an N-bit code is one of
// the 2N legal Johnson states and converts it to its state index.
module johnson_code_check
   import johnson_decoder_pkg::*;
#(
   parameter int N  = 5,
   parameter int IW = johnson_idx_width(N)
) (
   input  logic [N-1:0]  jin,
   output logic          legal,
   output logic [IW-1:0] idx_next
);

   logic [IW-1:0] edge_cnt;
   logic [IW-1:0] one_cnt;

   // Count adjacent-bit transitions and ones, then derive legality and index
   always_comb begin
      edge_cnt = '0;
      one_cnt  = '0;
      for (int i = 0; i < N - 1; i++) begin
         edge_cnt = edge_cnt + IW'(jin[i] ^ jin[i+1]);
      end
      for (int i = 0; i < N; i++) begin
         one_cnt = one_cnt + IW'(jin[i]);
      end
      // A Johnson code is a single run of ones at one end: at most one edge
      legal = (edge_cnt <= IW'(1));
      // Upper half of the cycle (MSB set) counts down from 2N; modular
      // arithmetic keeps this correct when 2N is a power of two
      if (jin[N-1]) begin
         idx_next = IW'(2 * N) - one_cnt;
      end else begin
         idx_next = one_cnt;
      end
   end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-counter receive-side monitor: decodes sampled codes to index and
// one-hot, tracks lock, flags illegal codes and out-of-order steps, and
// counts completed cycles with a saturating wrap counter.
module johnson_decoder
   import johnson_decoder_pkg::*;
#(
   parameter  int N      = 5,
   parameter  int WRAP_W = 8,
   localparam int IW     = johnson_idx_width(N)
) (
   input  logic              clock,
   input  logic              Reset,
   input  logic              en,
   input  logic [N-1:0]      jin,
   output logic [IW-1:0]     idx,
   output logic [2*N-1:0]    onehot,
   output logic              valid,
   output logic              locked,
   output logic              code_err,
   output logic              seq_err,
   output logic [WRAP_W-1:0] wraps
);

   localparam logic [IW-1:0] LAST_IDX = IW'(2 * N - 1);

   logic              legal;
   logic [IW-1:0]     idx_next;
   logic [IW-1:0]     idx_succ;
   logic [2*N-1:0]    onehot_next;
   logic [0:0]        state;

   logic [0:0]        state_d;
   logic [IW-1:0]     idx_d;
   logic [2*N-1:0]    onehot_d;
   logic              valid_d;
   logic              code_err_d;
   logic              seq_err_d;
   logic [WRAP_W-1:0] wraps_d;

   johnson_code_check #(
      .N  (N),
      .IW (IW)
   ) u_code_check (
      .jin      (jin),
      .legal    (legal),
      .idx_next (idx_next)
   );

   // Expected successor of the registered index (wraps at 2N) and the
   // one-hot image of the incoming sample
   always_comb begin
      if (idx == LAST_IDX) begin
         idx_succ = '0;
      end else begin
         idx_succ = idx + IW'(1);
      end
      onehot_next = {{(2*N-1){1'b0}}, 1'b1} << idx_next;
   end

   // Lock FSM and next values for all registered outputs
   always_comb begin
      state_d    = state;
      idx_d      = idx;
      onehot_d   = onehot;
      valid_d    = valid;
      code_err_d = 1'b0;
      seq_err_d  = 1'b0;
      wraps_d    = wraps;
      if (en) begin
         if (!legal) begin
            // Illegal code always drops lock; index is kept for diagnosis
            code_err_d = 1'b1;
            valid_d    = 1'b0;
            onehot_d   = '0;
            state_d    = S_UNLOCKED;
         end else begin
            case (state)
               S_UNLOCKED: begin
                  idx_d    = idx_next;
                  onehot_d = onehot_next;
                  valid_d  = 1'b1;
                  state_d  = S_LOCKED;
               end
               S_LOCKED: begin
                  if (idx_next == idx) begin
                     idx_d = idx;
                  end else if (idx_next == idx_succ) begin
                     idx_d    = idx_next;
                     onehot_d = onehot_next;
                     if ((idx == LAST_IDX) && (wraps != '1)) begin
                        wraps_d = wraps + WRAP_W'(1);
                     end else begin
                        wraps_d = wraps;
                     end
                  end else begin
                     // Skipped or backward step: flag it and resync
                     seq_err_d = 1'b1;
                     idx_d     = idx_next;
                     onehot_d  = onehot_next;
                  end
               end
               default: begin
                  state_d  = S_UNLOCKED;
                  valid_d  = 1'b0;
                  onehot_d = '0;
               end
            endcase
         end
      end else begin
         state_d = state;
      end
   end

   // Output and state registers, cleared asynchronously by Reset
   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         state    <= S_UNLOCKED;
         idx      <= '0;
         onehot   <= '0;
         valid    <= 1'b0;
         code_err <= 1'b0;
         seq_err  <= 1'b0;
         wraps    <= '0;
      end else begin
         state    <= state_d;
         idx      <= idx_d;
         onehot   <= onehot_d;
         valid    <= valid_d;
         code_err <= code_err_d;
         seq_err  <= seq_err_d;
         wraps    <= wraps_d;
      end
   end

   assign locked = (state == S_LOCKED);

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed, table-driven bench for johnson_decoder (N=5, WRAP_W=8).
module tb_johnson_decoder;

   logic       clock;
   logic       Reset;
   logic       en;
   logic [4:0] jin;
   logic [3:0] idx;
   logic [9:0] onehot;
   logic       valid;
   logic       locked;
   logic       code_err;
   logic       seq_err;
   logic [7:0] wraps;

   int tests    = 0;
   int failures = 0;

   typedef struct {
      logic       en;
      logic [4:0] jin;
      logic [3:0] idx;
      logic       valid;
      logic       locked;
      logic       code_err;
      logic       seq_err;
      logic [7:0] wraps;
   } vec_t;

   vec_t vecs[$];

   johnson_decoder #(
      .N      (5),
      .WRAP_W (8)
   ) dut (
      .clock    (clock),
      .Reset    (Reset),
      .en       (en),
      .jin      (jin),
      .idx      (idx),
      .onehot   (onehot),
      .valid    (valid),
      .locked   (locked),
      .code_err (code_err),
      .seq_err  (seq_err),
      .wraps    (wraps)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s [step %0d]: got 0x%0h, want 0x%0h", name, k, got, want);
      end
   endtask

   task automatic check_all(input int k, input logic [3:0] ei, input logic ev, input logic el,
                            input logic ece, input logic ese, input logic [7:0] ew);
      logic [9:0] eoh;
      eoh = ev ? (10'd1 << ei) : 10'd0;
      chk("idx",      k, 32'(idx),      32'(ei));
      chk("onehot",   k, 32'(onehot),   32'(eoh));
      chk("valid",    k, 32'(valid),    32'(ev));
      chk("locked",   k, 32'(locked),   32'(el));
      chk("code_err", k, 32'(code_err), 32'(ece));
      chk("seq_err",  k, 32'(seq_err),  32'(ese));
      chk("wraps",    k, 32'(wraps),    32'(ew));
   endtask

   task automatic add(input logic e, input logic [4:0] j, input int i, input logic v,
                      input logic l, input logic ce, input logic se, input int w);
      vec_t t;
      t.en = e; t.jin = j; t.idx = 4'(i); t.valid = v; t.locked = l;
      t.code_err = ce; t.seq_err = se; t.wraps = 8'(w);
      vecs.push_back(t);
   endtask

   initial begin
      logic [4:0] j;
      int         e_idx;
      int         bad;

      // en, jin, idx, valid, locked, code_err, seq_err, wraps
      // first lock and a full cycle with one wrap
      add(1'b1, 5'b00000, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      add(1'b1, 5'b00001, 1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      add(1'b1, 5'b00011, 2, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      add(1'b1, 5'b00111, 3, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      add(1'b1, 5'b01111, 4, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      add(1'b1, 5'b11111, 5, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      add(1'b1, 5'b11110, 6, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      add(1'b1, 5'b11100, 7, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      add(1'b1, 5'b11000, 8, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      add(1'b1, 5'b10000, 9, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      add(1'b1, 5'b00000, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
      // illegal code while locked at 3, then relock on the same state
      add(1'b1, 5'b00001, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1);
      add(1'b1, 5'b00011, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1);
      add(1'b1, 5'b00111, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1);
      add(1'b1, 5'b00100, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1);
      add(1'b1, 5'b00111, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1);
      // sequence errors: backward step, skip 2->4, and 8->0 without a wrap
      add(1'b1, 5'b00011, 2, 1'b1, 1'b1, 1'b0, 1'b1, 1);
      add(1'b1, 5'b01111, 4, 1'b1, 1'b1, 1'b0, 1'b1, 1);
      add(1'b1, 5'b11111, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1);
      add(1'b1, 5'b11110, 6, 1'b1, 1'b1, 1'b0, 1'b0, 1);
      add(1'b1, 5'b11100, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1);
      add(1'b1, 5'b11000, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1);
      add(1'b1, 5'b00000, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1);
      // holds, then en=0 freezes everything and ignores jin
      add(1'b1, 5'b00000, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
      add(1'b1, 5'b00000, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
      add(1'b0, 5'b10101, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
      add(1'b0, 5'b00111, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
      // illegal drops lock, en=0 clears the pulse, illegal while unlocked, relock
      add(1'b1, 5'b01010, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
      add(1'b0, 5'b00001, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      add(1'b1, 5'b11011, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
      add(1'b1, 5'b00000, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1);

      // reset state
      Reset = 1'b1;
      en    = 1'b0;
      jin   = 5'b00000;
      repeat (2) @(posedge clock);
      #1;
      check_all(-1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      @(negedge clock);
      Reset = 1'b0;

      // table-driven vectors
      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clock);
         en  = vecs[k].en;
         jin = vecs[k].jin;
         @(posedge clock);
         #1;
         check_all(k, vecs[k].idx, vecs[k].valid, vecs[k].locked,
                   vecs[k].code_err, vecs[k].seq_err, vecs[k].wraps);
      end

      // 300 full laps from idx 0 with wraps=1: counter must saturate at 255
      j     = 5'b00000;
      e_idx = 0;
      bad   = 0;
      for (int lap = 0; lap < 300; lap++) begin
         for (int s = 0; s < 10; s++) begin
            @(negedge clock);
            j     = {j[3:0], ~j[4]};
            e_idx = (e_idx + 1) % 10;
            en    = 1'b1;
            jin   = j;
            @(posedge clock);
            #1;
            if ((32'(idx) != e_idx) || code_err || seq_err || !valid || !locked) bad++;
         end
      end
      chk("lap_step_errors", 1000, bad, 0);
      check_all(1001, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd255);

      // Reset asserted between edges clears outputs before the next edge
      @(negedge clock);
      en  = 1'b1;
      jin = 5'b00001;
      #2;
      Reset = 1'b1;
      #1;
      check_all(1002, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      @(negedge clock);
      Reset = 1'b0;
      en    = 1'b1;
      jin   = 5'b00111;
      @(posedge clock);
      #1;
      check_all(1003, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
      en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
